// File: rtl/deser4_pkg.sv
// Shared constants and slot mapping for the 4-bit deserializer.
// Arrival order k (0 = first bit) maps to word slot k, or 3-k when MSB first.
package deser4_pkg;

    localparam int WORD_W = 4;
    localparam int CNT_W  = 2;

    function automatic logic [CNT_W-1:0] slot_idx(input logic [CNT_W-1:0] cnt,
                                                  input logic             msb_first);
        logic [CNT_W-1:0] idx;
        if (msb_first) begin
            idx = 2'd3 - cnt;
        end else begin
            idx = cnt;
        end
        return idx;
    endfunction

endpackage

// File: rtl/deser4_shift.sv
// Bit collector: tracks the arrival count, keeps the first three bits in
// arrival order and emits the assembled word with a one-cycle done strobe.
module deser4_shift
    import deser4_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              CK,
    input  logic              CDN,
    input  logic              SI,
    input  logic              SV,
    input  logic              SYNC,
    output logic [WORD_W-1:0] word,
    output logic              done
);

    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [WORD_W-2:0] sr_r;
    logic [WORD_W-2:0] sr_nxt_s;

    // Next count / partial bits and the completion strobe
    always_comb begin
        cnt_nxt_s = cnt_r;
        sr_nxt_s  = sr_r;
        done      = 1'b0;
        if (SYNC) begin
            // A resync bit always starts a fresh word, so it can never complete one
            sr_nxt_s = 3'b000;
            if (SV) begin
                sr_nxt_s[0] = SI;
                cnt_nxt_s   = 2'd1;
            end else begin
                cnt_nxt_s   = 2'd0;
            end
        end else if (SV) begin
            if (cnt_r == 2'd3) begin
                cnt_nxt_s = 2'd0;
                done      = 1'b1;
            end else begin
                for (int i = 0; i < WORD_W - 1; i++) begin
                    sr_nxt_s[i] = (cnt_r == CNT_W'(i)) ? SI : sr_r[i];
                end
                cnt_nxt_s = cnt_r + 2'd1;
            end
        end else begin
            cnt_nxt_s = cnt_r;
            sr_nxt_s  = sr_r;
        end
    end

    // Word assembly: stored bits plus the live fourth bit, placed by slot mapping
    always_comb begin
        word = {WORD_W{1'b0}};
        for (int i = 0; i < WORD_W - 1; i++) begin
            word[slot_idx(CNT_W'(i), MSB_FIRST)] = sr_r[i];
        end
        word[slot_idx(2'd3, MSB_FIRST)] = SI;
    end

    // Count and partial-bit registers
    always_ff @(posedge CK) begin
        if (!CDN) begin
            cnt_r <= 2'd0;
            sr_r  <= 3'b000;
        end else begin
            cnt_r <= cnt_nxt_s;
            sr_r  <= sr_nxt_s;
        end
    end

endmodule

// File: rtl/deser4_sync.sv
// 4-bit serial-to-parallel deserializer with registered valid/ready output
// holding stage, frame resync and a sticky overflow flag.
module deser4_sync
    import deser4_pkg::*;
#(
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit OVF_CLR_EN = 1'b1
) (
    input  logic              CK,
    input  logic              CDN,
    input  logic              SI,
    input  logic              SV,
    input  logic              SYNC,
    input  logic              RDY,
    input  logic              CLR_OVF,
    output logic [WORD_W-1:0] Q,
    output logic              QV,
    output logic              OVF
);

    logic [WORD_W-1:0] word_s;
    logic              done_s;
    logic [WORD_W-1:0] q_r;
    logic [WORD_W-1:0] q_nxt_s;
    logic              qv_r;
    logic              qv_nxt_s;
    logic              ovf_r;
    logic              ovf_nxt_s;
    logic              drop_s;

    deser4_shift #(
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .CK   (CK),
        .CDN  (CDN),
        .SI   (SI),
        .SV   (SV),
        .SYNC (SYNC),
        .word (word_s),
        .done (done_s)
    );

    // Holding-register handshake and overflow next state
    always_comb begin
        q_nxt_s   = q_r;
        qv_nxt_s  = qv_r;
        ovf_nxt_s = ovf_r;
        drop_s    = done_s && qv_r && !RDY;
        if (done_s && !drop_s) begin
            // Covers both an empty holder and a same-edge accept-and-reload
            q_nxt_s  = word_s;
            qv_nxt_s = 1'b1;
        end else if (qv_r && RDY) begin
            qv_nxt_s = 1'b0;
        end else begin
            qv_nxt_s = qv_r;
        end
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (CLR_OVF && OVF_CLR_EN) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Output registers
    always_ff @(posedge CK) begin
        if (!CDN) begin
            q_r   <= 4'b0000;
            qv_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            q_r   <= q_nxt_s;
            qv_r  <= qv_nxt_s;
            ovf_r <= ovf_nxt_s;
        end
    end

    assign Q   = q_r;
    assign QV  = qv_r;
    assign OVF = ovf_r;

endmodule
